// File: rtl/drawing_pkg.sv
// Shared types and defaults for the drawing dispatch block.
package drawing_pkg;

    localparam int DRAWING_NUM_CH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        ERR  = 2'd3
    } draw_state_t;

endpackage

// File: rtl/drawing_timeout.sv
// Wait-cycle counter for a dispatched request; only built when DRAWING_DISPATCH_TIMEOUT_EN is defined.
module drawing_timeout #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] count_r;

    // Counts edges spent waiting; cleared whenever the request is not pending, saturates at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (!run) begin
            count_r <= '0;
        end else if (count_r != CNT_W'(TIMEOUT_CYC)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Fires on the edge that would make the TIMEOUT_CYC-th waiting edge.
    assign expired = run && (count_r == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/drawing_dispatch.sv
// Routes an upstream four-phase request to one of NUM_CH drawing units.
// Optional ack timeout enabled by defining DRAWING_DISPATCH_TIMEOUT_EN.
module drawing_dispatch
    import drawing_pkg::*;
#(
    parameter int NUM_CH      = DRAWING_NUM_CH,
    parameter int CMD_W       = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              de_req,
    input  logic [CMD_W-1:0]  de_cmd,
    output logic [NUM_CH-1:0] de_req_o,
    input  logic [NUM_CH-1:0] de_ack_i,
    output logic              de_ack,
    output logic              de_err,
    output logic              de_busy
);

    localparam logic [CMD_W:0]    NUM_CH_W = (CMD_W + 1)'(NUM_CH);
    localparam logic [NUM_CH-1:0] ONE_CH   = {{(NUM_CH - 1){1'b0}}, 1'b1};

    draw_state_t       state_r;
    draw_state_t       state_nxt_s;
    logic [CMD_W-1:0]  cmd_q_r;
    logic [CMD_W-1:0]  cmd_nxt_s;
    logic              cmd_ok_s;
    logic              sel_ack_s;
    logic              timeout_s;
    logic [NUM_CH-1:0] req_o_nxt_s;
    logic              ack_nxt_s;
    logic              err_nxt_s;
    logic              busy_nxt_s;

    assign cmd_ok_s  = ({1'b0, de_cmd} < NUM_CH_W);
    // Only the acknowledge of the latched target is ever looked at.
    assign sel_ack_s = |(de_ack_i & (ONE_CH << cmd_q_r));

`ifdef DRAWING_DISPATCH_TIMEOUT_EN
    drawing_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .run     (state_r == REQ),
        .expired (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // State and latched target register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cmd_q_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            cmd_q_r <= cmd_nxt_s;
        end
    end

    // Next-state and target-latch decision.
    always_comb begin
        state_nxt_s = state_r;
        cmd_nxt_s   = cmd_q_r;
        case (state_r)
            IDLE: begin
                if (de_req) begin
                    state_nxt_s = cmd_ok_s ? REQ : ERR;
                    cmd_nxt_s   = de_cmd;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (sel_ack_s) begin
                    state_nxt_s = ACK;
                end else if (timeout_s) begin
                    state_nxt_s = ERR;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            ACK: begin
                if (!de_req && !sel_ack_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ACK;
                end
            end
            ERR: begin
                if (!de_req) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ERR;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output values derived from the upcoming state so they register alongside it.
    always_comb begin
        req_o_nxt_s = '0;
        ack_nxt_s   = 1'b0;
        err_nxt_s   = 1'b0;
        busy_nxt_s  = 1'b1;
        case (state_nxt_s)
            IDLE: busy_nxt_s  = 1'b0;
            REQ:  req_o_nxt_s = ONE_CH << cmd_nxt_s;
            ACK:  ack_nxt_s   = 1'b1;
            ERR: begin
                ack_nxt_s = 1'b1;
                err_nxt_s = 1'b1;
            end
            default: busy_nxt_s = 1'b0;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_req_o <= '0;
            de_ack   <= 1'b0;
            de_err   <= 1'b0;
            de_busy  <= 1'b0;
        end else begin
            de_req_o <= req_o_nxt_s;
            de_ack   <= ack_nxt_s;
            de_err   <= err_nxt_s;
            de_busy  <= busy_nxt_s;
        end
    end

endmodule

// File: tb/tb_drawing_dispatch.sv
// Randomized bench for drawing_dispatch: a 4-channel and a 3-channel instance share stimulus
// and are compared every cycle against a transaction-level reference model.
module tb_drawing_dispatch;

    localparam int TO = 8;
`ifdef DRAWING_DISPATCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       de_req = 1'b0;
    logic [1:0] de_cmd = 2'd0;
    logic [3:0] de_ack_i = 4'd0;
    logic [3:0] req_o4;
    logic [2:0] req_o3;
    logic       ack4, err4, busy4, ack3, err3, busy3;

    int n_checks = 0;
    int n_pass = 0;

    // Model: phase 0 = idle, 1 = waiting on unit, 2 = acknowledged, 3 = error.
    int nch[2] = '{4, 3};
    int m_ph[2];
    int m_cmd[2];
    int m_wait[2];

    drawing_dispatch #(.NUM_CH(4), .CMD_W(2), .TIMEOUT_CYC(TO)) u_dut4 (
        .clk(clk), .reset(reset), .de_req(de_req), .de_cmd(de_cmd),
        .de_req_o(req_o4), .de_ack_i(de_ack_i), .de_ack(ack4), .de_err(err4), .de_busy(busy4)
    );

    drawing_dispatch #(.NUM_CH(3), .CMD_W(2), .TIMEOUT_CYC(TO)) u_dut3 (
        .clk(clk), .reset(reset), .de_req(de_req), .de_cmd(de_cmd),
        .de_req_o(req_o3), .de_ack_i(de_ack_i[2:0]), .de_ack(ack3), .de_err(err3), .de_busy(busy3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = 0; m_cmd[k] = 0; m_wait[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            case (m_ph[k])
                0: if (de_req) begin
                    m_cmd[k]  = int'(de_cmd);
                    m_wait[k] = 0;
                    m_ph[k]   = (int'(de_cmd) < nch[k]) ? 1 : 3;
                end
                1: begin
                    m_wait[k]++;
                    if (de_ack_i[m_cmd[k]]) m_ph[k] = 2;
                    else if (TO_EN && m_wait[k] == TO) m_ph[k] = 3;
                end
                2: if (!de_req && !de_ack_i[m_cmd[k]]) m_ph[k] = 0;
                3: if (!de_req) m_ph[k] = 0;
                default: m_ph[k] = 0;
            endcase
        end
    endtask

    task automatic compare();
        logic [3:0] got_req [2];
        logic       got_ack [2], got_err [2], got_busy [2];
        got_req[0] = req_o4; got_req[1] = {1'b0, req_o3};
        got_ack[0] = ack4;   got_ack[1] = ack3;
        got_err[0] = err4;   got_err[1] = err3;
        got_busy[0] = busy4; got_busy[1] = busy3;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("req_o[ch%0d]", nch[k]), 32'(got_req[k]),
                  (m_ph[k] == 1) ? (32'd1 << m_cmd[k]) : 32'd0);
            check($sformatf("ack[ch%0d]", nch[k]), 32'(got_ack[k]), 32'(m_ph[k] == 2 || m_ph[k] == 3));
            check($sformatf("err[ch%0d]", nch[k]), 32'(got_err[k]), 32'(m_ph[k] == 3));
            check($sformatf("busy[ch%0d]", nch[k]), 32'(got_busy[k]), 32'(m_ph[k] != 0));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    // Asynchronous reset pulse placed between edges; outputs must clear without a clock.
    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1 model_reset();
        check("rst_req_o4", 32'(req_o4), 32'd0);
        check("rst_ack4", 32'(ack4), 32'd0);
        check("rst_busy4", 32'(busy4), 32'd0);
        compare();
        #1 reset = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 compare();
        #2 reset = 1'b0;

        // Channel 2 dispatch, ack on the third edge after the request.
        de_req = 1'b1; de_cmd = 2'd2;
        step();
        check("dispatch_ch2", 32'(req_o4), 32'h4);
        step(); step();
        de_ack_i = 4'b0100;
        step();
        check("done_req_o", 32'(req_o4), 32'h0);
        check("done_ack", 32'(ack4), 32'h1);
        check("done_err", 32'(err4), 32'h0);
        de_req = 1'b0; de_ack_i = 4'd0;
        step(); step();

        // Command 3: invalid on the 3-channel instance, valid on the 4-channel one.
        de_req = 1'b1; de_cmd = 2'd3;
        step();
        check("bad_cmd_ack", 32'(ack3), 32'h1);
        check("bad_cmd_err", 32'(err3), 32'h1);
        check("bad_cmd_req_o", 32'(req_o3), 32'h0);
        de_req = 1'b0;
        step();
        check("bad_cmd_idle", 32'(busy3), 32'h0);
        de_ack_i = 4'b1000; step();
        de_ack_i = 4'd0; step(); step();

        // Foreign acks ignored on channel 1.
        de_req = 1'b1; de_cmd = 2'd1;
        step();
        de_ack_i = 4'b1101;
        repeat (3) begin
            step();
            check("foreign_ack", 32'(ack4), 32'h0);
        end
        de_ack_i = 4'b1111;
        step();
        check("own_ack", 32'(ack4), 32'h1);
        de_req = 1'b0; de_ack_i = 4'd0;
        step(); step();

        // Command changes while busy on channel 0.
        de_req = 1'b1; de_cmd = 2'd0;
        step();
        de_cmd = 2'd3;
        repeat (3) begin
            step();
            check("cmd_held", 32'(req_o4), 32'h1);
        end
        de_ack_i = 4'b0001; step();
        de_req = 1'b0; de_ack_i = 4'd0; step(); step();

        // Reset mid-transaction on channel 0; a late ack must not complete anything.
        de_req = 1'b1; de_cmd = 2'd0;
        step();
        pulse_reset();
        de_req = 1'b0; de_ack_i = 4'b0001;
        step();
        check("no_ack_after_rst", 32'(ack4), 32'h0);
        step();
        de_ack_i = 4'd0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            de_req   = ($urandom % 4) != 0;
            de_cmd   = 2'($urandom % 4);
            de_ack_i = 4'($urandom % 16);
            if ($urandom % 150 == 0) pulse_reset();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
